// File: rtl/branch_target_buffer_if.sv
// Lookup, resolve/update and statistics signals between the fetch/memory stages and the BTB.
// The BTB sits on the slave side; the pipeline (or a bench) drives the master side.
interface branch_target_buffer_if #(
   parameter int unsigned XLEN = 32
);
   logic [XLEN-1:0] lk_pc;
   logic            lk_hit;
   logic            lk_taken;
   logic [XLEN-1:0] lk_target;
   logic            upd_valid;
   logic [XLEN-1:0] upd_pc;
   logic            upd_taken;
   logic [XLEN-1:0] upd_target;
   logic            upd_pred_taken;
   logic [XLEN-1:0] upd_pred_target;
   logic            inv_all;
   logic            mispredict;
   logic [XLEN-1:0] redirect_pc;
   logic [31:0]     stat_branches;
   logic [31:0]     stat_mispred;

   modport master (
      output lk_pc, upd_valid, upd_pc, upd_taken, upd_target,
             upd_pred_taken, upd_pred_target, inv_all,
      input  lk_hit, lk_taken, lk_target, mispredict, redirect_pc,
             stat_branches, stat_mispred
   );

   modport slave (
      input  lk_pc, upd_valid, upd_pc, upd_taken, upd_target,
             upd_pred_taken, upd_pred_target, inv_all,
      output lk_hit, lk_taken, lk_target, mispredict, redirect_pc,
             stat_branches, stat_mispred
   );
endinterface

// File: rtl/branch_target_buffer.sv
// Direct-mapped branch target buffer with saturating direction counters, combinational lookup,
// MEM-stage misprediction detection, bulk invalidate and saturating statistics counters.
module branch_target_buffer #(
   parameter int unsigned XLEN     = 32,
   parameter int unsigned ENTRIES  = 16,
   parameter int unsigned CNT_W    = 2,
   parameter int unsigned CNT_INIT = 2
) (
   input logic                  clk,
   input logic                  rst,
   branch_target_buffer_if.slave bus
);
   localparam int unsigned IDX_W = $clog2(ENTRIES);
   localparam int unsigned TAG_W = XLEN - 2 - IDX_W;
   localparam logic [CNT_W-1:0] CNT_MAX = '1;
   localparam logic [CNT_W-1:0] CNT_RST = CNT_W'(CNT_INIT);
   localparam logic [31:0]      STAT_MAX = '1;

   logic             valid_q [ENTRIES];
   logic             valid_d [ENTRIES];
   logic [TAG_W-1:0] tag_q   [ENTRIES];
   logic [TAG_W-1:0] tag_d   [ENTRIES];
   logic [XLEN-1:0]  tgt_q   [ENTRIES];
   logic [XLEN-1:0]  tgt_d   [ENTRIES];
   logic [CNT_W-1:0] cnt_q   [ENTRIES];
   logic [CNT_W-1:0] cnt_d   [ENTRIES];
   logic [31:0]      stat_br_q, stat_br_d;
   logic [31:0]      stat_mp_q, stat_mp_d;

   logic [IDX_W-1:0] lk_idx, upd_idx;
   logic [TAG_W-1:0] lk_tag, upd_tag;
   logic             lk_hit_c, lk_taken_c, upd_hit_c, mispredict_c;
   logic             unused_pc_bits;

   assign lk_idx  = bus.lk_pc[IDX_W+1:2];
   assign lk_tag  = bus.lk_pc[XLEN-1:IDX_W+2];
   assign upd_idx = bus.upd_pc[IDX_W+1:2];
   assign upd_tag = bus.upd_pc[XLEN-1:IDX_W+2];
   assign unused_pc_bits = ^{bus.lk_pc[1:0], bus.upd_pc[1:0]};

   // Lookup reads only registered table state, so same-cycle updates are never bypassed.
   assign lk_hit_c      = valid_q[lk_idx] && (tag_q[lk_idx] == lk_tag);
   assign lk_taken_c    = lk_hit_c && cnt_q[lk_idx][CNT_W-1];
   assign bus.lk_hit    = lk_hit_c;
   assign bus.lk_taken  = lk_taken_c;
   assign bus.lk_target = lk_taken_c ? tgt_q[lk_idx] : bus.lk_pc + XLEN'(4);

   assign upd_hit_c    = valid_q[upd_idx] && (tag_q[upd_idx] == upd_tag);
   assign mispredict_c = bus.upd_valid &&
                         ((bus.upd_pred_taken != bus.upd_taken) ||
                          (bus.upd_taken && (bus.upd_pred_target != bus.upd_target)));
   assign bus.mispredict    = mispredict_c;
   assign bus.redirect_pc   = bus.upd_taken ? bus.upd_target : bus.upd_pc + XLEN'(4);
   assign bus.stat_branches = stat_br_q;
   assign bus.stat_mispred  = stat_mp_q;

   // Table next state: invalidate wins over the resolved-branch update.
   always_comb begin
      valid_d = valid_q;
      tag_d   = tag_q;
      tgt_d   = tgt_q;
      cnt_d   = cnt_q;
      if (bus.inv_all) begin
         for (int i = 0; i < int'(ENTRIES); i++) valid_d[i] = 1'b0;
      end else if (bus.upd_valid) begin
         if (upd_hit_c) begin
            if (bus.upd_taken) begin
               tgt_d[upd_idx] = bus.upd_target;
               if (cnt_q[upd_idx] != CNT_MAX) cnt_d[upd_idx] = cnt_q[upd_idx] + CNT_W'(1);
            end else if (cnt_q[upd_idx] != '0) begin
               cnt_d[upd_idx] = cnt_q[upd_idx] - CNT_W'(1);
            end
         end else if (bus.upd_taken) begin
            valid_d[upd_idx] = 1'b1;
            tag_d[upd_idx]   = upd_tag;
            tgt_d[upd_idx]   = bus.upd_target;
            cnt_d[upd_idx]   = CNT_RST;
         end
      end
   end

   always_comb begin
      stat_br_d = stat_br_q;
      stat_mp_d = stat_mp_q;
      if (bus.upd_valid && (stat_br_q != STAT_MAX)) stat_br_d = stat_br_q + 32'd1;
      if (mispredict_c && (stat_mp_q != STAT_MAX))  stat_mp_d = stat_mp_q + 32'd1;
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         for (int i = 0; i < int'(ENTRIES); i++) begin
            valid_q[i] <= 1'b0;
            tag_q[i]   <= '0;
            tgt_q[i]   <= '0;
            cnt_q[i]   <= CNT_RST;
         end
         stat_br_q <= '0;
         stat_mp_q <= '0;
      end else begin
         valid_q   <= valid_d;
         tag_q     <= tag_d;
         tgt_q     <= tgt_d;
         cnt_q     <= cnt_d;
         stat_br_q <= stat_br_d;
         stat_mp_q <= stat_mp_d;
      end
   end
endmodule

// File: tb/tb_branch_target_buffer.sv
// Scoreboard bench for branch_target_buffer: directed scenarios then random traffic against
// an array-based model of a 16-entry direct-mapped BTB.
module tb_branch_target_buffer;
   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   branch_target_buffer_if #(.XLEN(32)) bus ();
   branch_target_buffer #(.XLEN(32), .ENTRIES(16), .CNT_W(2), .CNT_INIT(2)) dut (
      .clk(clk), .rst(rst), .bus(bus)
   );

   typedef struct {
      logic        hit;
      logic        taken;
      logic [31:0] tgt;
      logic        mp;
      logic [31:0] rpc;
      logic [31:0] sb;
      logic [31:0] sm;
   } exp_t;

   exp_t exp_q[$];
   int   total = 0;
   int   bad   = 0;

   // Reference model state
   bit          m_valid [16];
   int unsigned m_tag   [16];
   logic [31:0] m_tgt   [16];
   int          m_cnt   [16];
   longint unsigned m_sb, m_sm;

   // Stimulus currently applied
   logic [31:0] s_lk_pc, s_upc, s_utgt, s_uptgt;
   logic        s_uv, s_ut, s_upt, s_inv, s_rst;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic int unsigned idx_of(input logic [31:0] pc);
      return (pc >> 2) % 16;
   endfunction

   function automatic int unsigned tag_of(input logic [31:0] pc);
      return pc >> 6;
   endfunction

   function automatic bit m_hit(input logic [31:0] pc);
      return m_valid[idx_of(pc)] && (m_tag[idx_of(pc)] == tag_of(pc));
   endfunction

   function automatic bit m_taken(input logic [31:0] pc);
      return m_hit(pc) && (m_cnt[idx_of(pc)] >= 2);
   endfunction

   function automatic logic [31:0] m_target(input logic [31:0] pc);
      return m_taken(pc) ? m_tgt[idx_of(pc)] : pc + 32'd4;
   endfunction

   function automatic bit m_mp();
      return s_uv && ((s_upt != s_ut) || (s_ut && (s_uptgt != s_utgt)));
   endfunction

   task automatic m_reset();
      for (int i = 0; i < 16; i++) begin
         m_valid[i] = 0; m_tag[i] = 0; m_tgt[i] = 0; m_cnt[i] = 2;
      end
      m_sb = 0; m_sm = 0;
   endtask

   // Effect of one rising edge on the model, using the stimulus held during that cycle.
   task automatic m_edge();
      int unsigned i;
      bit mp;
      if (!s_rst) begin
         m_reset();
         return;
      end
      mp = m_mp();
      if (s_uv) m_sb = (m_sb >= 64'hFFFF_FFFF) ? 64'hFFFF_FFFF : m_sb + 1;
      if (mp)   m_sm = (m_sm >= 64'hFFFF_FFFF) ? 64'hFFFF_FFFF : m_sm + 1;
      if (s_inv) begin
         for (int k = 0; k < 16; k++) m_valid[k] = 0;
      end else if (s_uv) begin
         i = idx_of(s_upc);
         if (m_hit(s_upc)) begin
            if (s_ut) begin
               m_cnt[i] = (m_cnt[i] == 3) ? 3 : m_cnt[i] + 1;
               m_tgt[i] = s_utgt;
            end else begin
               m_cnt[i] = (m_cnt[i] == 0) ? 0 : m_cnt[i] - 1;
            end
         end else if (s_ut) begin
            m_valid[i] = 1; m_tag[i] = tag_of(s_upc); m_tgt[i] = s_utgt; m_cnt[i] = 2;
         end
      end
   endtask

   // Apply one cycle of stimulus, queue the expected response, then advance past the edge.
   task automatic cyc(input logic [31:0] lk, input logic uv, input logic [31:0] upc,
                      input logic ut, input logic [31:0] utgt, input logic upt,
                      input logic [31:0] uptgt, input logic inv, input logic r);
      exp_t e;
      s_lk_pc = lk; s_uv = uv; s_upc = upc; s_ut = ut; s_utgt = utgt;
      s_upt = upt; s_uptgt = uptgt; s_inv = inv; s_rst = r;
      bus.lk_pc = lk; bus.upd_valid = uv; bus.upd_pc = upc; bus.upd_taken = ut;
      bus.upd_target = utgt; bus.upd_pred_taken = upt; bus.upd_pred_target = uptgt;
      bus.inv_all = inv; rst = r;
      e.hit   = m_hit(lk);
      e.taken = m_taken(lk);
      e.tgt   = m_target(lk);
      e.mp    = m_mp();
      e.rpc   = ut ? utgt : upc + 32'd4;
      e.sb    = 32'(m_sb);
      e.sm    = 32'(m_sm);
      exp_q.push_back(e);
      @(posedge clk);
      m_edge();
      #1;
   endtask

   task automatic look(input logic [31:0] lk);
      cyc(lk, 0, 0, 0, 0, 0, 0, 0, 1);
   endtask

   // Resolved branch whose carried prediction is what the model's lookup gives for it.
   task automatic upd_auto(input logic [31:0] pc, input logic t, input logic [31:0] tg);
      cyc(pc, 1, pc, t, tg, m_taken(pc), m_target(pc), 0, 1);
   endtask

   // Monitor: compare at the falling edge whenever an expected response is pending.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("lk_hit",        32'(bus.lk_hit),     32'(e.hit));
            chk("lk_taken",      32'(bus.lk_taken),   32'(e.taken));
            chk("lk_target",     bus.lk_target,       e.tgt);
            chk("mispredict",    32'(bus.mispredict), 32'(e.mp));
            if (e.mp) chk("redirect_pc", bus.redirect_pc, e.rpc);
            chk("stat_branches", bus.stat_branches,   e.sb);
            chk("stat_mispred",  bus.stat_mispred,    e.sm);
         end
      end
   end

   initial begin
      logic [31:0] pool [8];
      logic [31:0] a, b, tg;
      logic t;
      rst = 1'b0;
      bus.lk_pc = 0; bus.upd_valid = 0; bus.upd_pc = 0; bus.upd_taken = 0;
      bus.upd_target = 0; bus.upd_pred_taken = 0; bus.upd_pred_target = 0; bus.inv_all = 0;
      s_rst = 0; s_uv = 0; s_inv = 0;
      repeat (2) @(posedge clk);
      m_reset();
      #1;

      // Reset state and first allocation
      look(32'h100);
      cyc(32'h100, 1, 32'h100, 1, 32'h200, 0, 32'h104, 0, 1);
      look(32'h100);
      // Counter walk down then back up
      repeat (3) upd_auto(32'h100, 0, 32'h0);
      look(32'h100);
      repeat (2) upd_auto(32'h100, 1, 32'h200);
      look(32'h100);
      // Target mismatch on a correctly predicted taken branch
      cyc(32'h100, 1, 32'h100, 1, 32'h208, 1, 32'h200, 0, 1);
      look(32'h100);
      // Alias replaces entry at same index
      upd_auto(32'h140, 1, 32'h300);
      look(32'h100);
      look(32'h140);
      // Invalidate overriding a same-cycle update
      cyc(32'h140, 1, 32'h180, 1, 32'h400, 0, 32'h184, 1, 1);
      look(32'h140);
      look(32'h180);
      // Same-cycle lookup and allocate
      cyc(32'h100, 1, 32'h100, 1, 32'h500, 0, 32'h104, 0, 1);
      look(32'h100);
      // pc+4 wrap at the top of the address space
      look(32'hFFFF_FFFC);
      cyc(32'h0, 1, 32'hFFFF_FFFC, 0, 32'h0, 1, 32'h10, 0, 1);
      // Mid-stream reset
      cyc(32'h100, 1, 32'h100, 1, 32'h500, 1, 32'h500, 0, 0);
      look(32'h100);

      // Random traffic over a small PC pool to force hits, misses and aliasing
      for (int i = 0; i < 8; i++) pool[i] = {24'($urandom_range(0, 1)), 8'($urandom_range(0, 7) * 4)} + 32'h1000;
      for (int n = 0; n < 600; n++) begin
         a  = pool[$urandom_range(0, 7)] | 32'($urandom_range(0, 3));
         b  = pool[$urandom_range(0, 7)] | 32'($urandom_range(0, 3));
         t  = 1'($urandom_range(0, 1));
         tg = 32'h8000 + 32'($urandom_range(0, 3)) * 4;
         if ($urandom_range(0, 99) < 70)
            cyc(a, 1'($urandom_range(0, 3) != 0), b, t, tg, m_taken(b), m_target(b),
                $urandom_range(0, 99) < 3, $urandom_range(0, 99) >= 1);
         else
            cyc(a, 1'($urandom_range(0, 1)), b, t, tg, 1'($urandom_range(0, 1)),
                32'h8000 + 32'($urandom_range(0, 3)) * 4, 1'b0, 1'b1);
      end

      @(posedge clk);
      @(posedge clk);
      chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
